// File: rtl/serial_word_deserializer_pkg.sv
// Shared types and sizing helpers for the serial word deserializer.
package serial_word_deserializer_pkg;

  localparam int STATE_W   = 1;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_deserializer_out_buf.sv
// One-entry valid/ready holding register; a word arriving while full and not
// draining is dropped and flagged in a sticky overflow bit.
module deser_out_buf
  import serial_word_deserializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overflow
);

  logic accept, take, drop;

  assign accept = valid && ready;
  assign take   = load && (!valid || accept);
  assign drop   = load && valid && !ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (take) begin
        data  <= word;
        valid <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end
      // a drop on the same edge outranks a clear
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// Samples an enable-qualified serial stream into WIDTH-bit words, optionally
// framed by a start bit, and hands them to a valid/ready consumer.
module serial_word_deserializer
  import serial_word_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit SYNC      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             busy
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n, shifted;
  logic             done;

  assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], in} : {in, sreg[WIDTH-1:1]};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    done    = 1'b0;
    if (enable) begin
      case (state)
        IDLE: if (in) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
        SHIFT: begin
          sreg_n = shifted;
          if (cnt == LAST) begin
            done  = 1'b1;
            cnt_n = '0;
            if (SYNC) state_n = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC ? IDLE : SHIFT;
      cnt   <= '0;
      sreg  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sreg  <= sreg_n;
      // free-running mode has no framing state, so busy tracks a partial word
      busy  <= SYNC ? (state_n == SHIFT) : (cnt_n != '0);
    end
  end

  deser_out_buf #(.WIDTH(WIDTH)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (done),
    .word     (sreg_n),
    .ready    (out_ready),
    .clr_ovf  (clr_ovf),
    .data     (out_data),
    .valid    (out_valid),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench: framed MSB-first instance and free-running LSB-first instance,
// directed cases plus randomized traffic against a bit-list word model.
module tb_serial_word_deserializer;

  localparam int W = 8;

  logic         clk, rst_n;
  logic         en[2], din[2], rdy[2], clr[2];
  logic [W-1:0] od[2];
  logic         ov[2], oo[2], ob[2];

  int cmp_n = 0, mis_n = 0;
  bit chk_on = 0;

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1), .SYNC(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .in(din[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
    .overflow(oo[0]), .clr_ovf(clr[0]), .busy(ob[0]));

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0), .SYNC(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .in(din[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
    .overflow(oo[1]), .clr_ovf(clr[1]), .busy(ob[1]));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic bit is_msb(input int i);  return i == 0; endfunction
  function automatic bit is_sync(input int i); return i == 0; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      mis_n++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: collect sampled data bits in a list; a full list becomes a word.
  bit       m_frame[2];
  bit       m_bits[2][W];
  int       m_n[2];
  bit       m_v[2], m_o[2], m_b[2];
  bit [W-1:0] m_d[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_frame[i] <= !is_sync(i);
        m_n[i] <= 0; m_v[i] <= 0; m_o[i] <= 0; m_b[i] <= 0; m_d[i] <= '0;
        for (int k = 0; k < W; k++) m_bits[i][k] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic bit fr = m_frame[i];
        automatic int n = m_n[i];
        automatic bit comp = 0;
        automatic bit acc = m_v[i] && rdy[i];
        automatic bit [W-1:0] word = '0;
        automatic bit v = m_v[i];
        automatic bit o = m_o[i];
        if (en[i]) begin
          if (!fr) begin
            if (din[i]) fr = 1;
          end else if (n == W - 1) begin
            for (int k = 0; k < W; k++) begin
              automatic bit b = (k == W - 1) ? din[i] : m_bits[i][k];
              if (is_msb(i)) word[W-1-k] = b; else word[k] = b;
            end
            comp = 1; n = 0;
            if (is_sync(i)) fr = 0;
          end else begin
            m_bits[i][n] <= din[i];
            n++;
          end
        end
        if (comp) begin
          if (!v || acc) begin m_d[i] <= word; v = 1; end
          else o = 1;
        end else if (acc) v = 0;
        if (!(comp && m_v[i] && !acc) && clr[i]) o = 0;
        m_frame[i] <= fr; m_n[i] <= n; m_v[i] <= v; m_o[i] <= o;
        m_b[i] <= is_sync(i) ? fr : (n != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("valid%0d", i), 32'(ov[i]), 32'(m_v[i]));
        chk($sformatf("ovf%0d", i), 32'(oo[i]), 32'(m_o[i]));
        chk($sformatf("busy%0d", i), 32'(ob[i]), 32'(m_b[i]));
        if (ov[i]) chk($sformatf("data%0d", i), 32'(od[i]), 32'(m_d[i]));
      end
    end
  end

  task automatic sbit(input int i, input logic b);
    en[i] = 1; din[i] = b;
    @(negedge clk);
    en[i] = 0; din[i] = 0;
  endtask

  task automatic frame0(input logic [W-1:0] w);
    sbit(0, 1);
    for (int k = W - 1; k >= 0; k--) sbit(0, w[k]);
  endtask

  initial begin
    logic [W-1:0] r;
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin en[i] = 0; din[i] = 0; rdy[i] = 0; clr[i] = 0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(ov[i]), 0);
      chk($sformatf("rst_data%0d", i), 32'(od[i]), 0);
      chk($sformatf("rst_ovf%0d", i), 32'(oo[i]), 0);
      chk($sformatf("rst_busy%0d", i), 32'(ob[i]), 0);
    end
    rst_n = 1;
    chk_on = 1;

    // free-running LSB-first: first bit lands in bit 0, no start bit
    rdy[1] = 1;
    sbit(1, 1);
    repeat (7) sbit(1, 0);
    chk("lsb_first_valid", 32'(ov[1]), 1);
    chk("lsb_first_data", 32'(od[1]), 32'h01);
    r = 8'h96;
    for (int k = 0; k < W; k++) sbit(1, r[k]);
    chk("lsb_second_data", 32'(od[1]), 32'h96);
    rdy[1] = 0;

    rdy[0] = 1;
    frame0(8'hA5);
    chk("basic_valid", 32'(ov[0]), 1);
    chk("basic_data", 32'(od[0]), 32'hA5);
    chk("basic_busy", 32'(ob[0]), 0);
    chk("basic_ovf", 32'(oo[0]), 0);
    @(negedge clk);

    // enable gaps with the line low must not be stored
    sbit(0, 1);
    r = 8'hA5;
    for (int k = W - 1; k >= 0; k--) begin
      sbit(0, r[k]);
      if (k == 5) repeat (3) @(negedge clk);
    end
    chk("gap_data", 32'(od[0]), 32'hA5);
    chk("gap_valid", 32'(ov[0]), 1);
    @(negedge clk);

    rdy[0] = 0;
    frame0(8'h3C);
    frame0(8'hC3);
    chk("bp_data", 32'(od[0]), 32'h3C);
    chk("bp_ovf", 32'(oo[0]), 1);
    clr[0] = 1; @(negedge clk); clr[0] = 0;
    chk("clr_ovf", 32'(oo[0]), 0);
    chk("clr_valid", 32'(ov[0]), 1);
    chk("clr_data", 32'(od[0]), 32'h3C);
    rdy[0] = 1; @(negedge clk); rdy[0] = 0;

    frame0(8'h11);
    r = 8'h22;
    sbit(0, 1);
    for (int k = W - 1; k >= 1; k--) sbit(0, r[k]);
    rdy[0] = 1;
    sbit(0, r[0]);
    chk("drain_valid", 32'(ov[0]), 1);
    chk("drain_data", 32'(od[0]), 32'h22);
    chk("drain_ovf", 32'(oo[0]), 0);

    // asynchronous reset in the middle of a frame
    rdy[0] = 0;
    frame0(8'h77);
    sbit(0, 1);
    repeat (4) sbit(0, 1);
    #2 rst_n = 0;
    #1;
    chk("amid_valid", 32'(ov[0]), 0);
    chk("amid_data", 32'(od[0]), 0);
    chk("amid_busy", 32'(ob[0]), 0);
    @(negedge clk);
    rst_n = 1;
    rdy[0] = 1;
    frame0(8'h5A);
    chk("post_rst_data", 32'(od[0]), 32'h5A);

    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        en[i]  = ($urandom_range(0, 3) != 0);
        din[i] = 1'($urandom);
        rdy[i] = ($urandom_range(0, 9) < 6);
        clr[i] = ($urandom_range(0, 31) == 0);
      end
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 0;
        #2 rst_n = 1;
      end
      @(negedge clk);
    end

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
    $finish;
  end

endmodule
